// File: rtl/ycbcr_component_scheduler.sv
// Runs one buffered RGB block through the shared YCbCr/DCT/quant pipeline as Y, Cb, then Cr.
// Optional WAIT_RES watchdog with sticky err_timeout: define SCHED_TIMEOUT_EN.
module ycbcr_component_scheduler #(
  parameter int INPUT_WIDTH    = 8,
  parameter int PIXEL_COUNT    = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0] s_r,
  input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0] s_g,
  input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0] s_b,
  output logic                               p_valid,
  input  logic                               p_ready,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] p_r,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] p_g,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0] p_b,
  output logic [1:0]                         p_sel,
  input  logic                               p_out_valid,
  output logic                               p_out_ready,
  input  logic [8*PIXEL_COUNT-1:0]           p_out_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [8*PIXEL_COUNT-1:0]           m_data,
  output logic [1:0]                         m_comp,
  output logic                               m_last,
  output logic                               busy,
  output logic                               err_timeout
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_RES = 2'd2;
  localparam logic [1:0] EMIT     = 2'd3;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CR = 2'd2;

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic [1:0] comp_reg;
  logic [1:0] comp_next;
  logic [1:0] m_comp_reg;
  logic       capture_in;
  logic       capture_out;
  logic       timeout_hit;

  // Handshake-visible controls are pure decodes of the state register, so they
  // follow the asynchronous reset in the same cycle it is asserted.
  assign s_ready     = (state_reg == IDLE);
  assign p_valid     = (state_reg == ISSUE);
  assign p_out_ready = (state_reg == WAIT_RES);
  assign m_valid     = (state_reg == EMIT);
  assign m_last      = (state_reg == EMIT) && (m_comp_reg == COMP_CR);
  assign busy        = (state_reg != IDLE);
  assign p_sel       = comp_reg;
  assign m_comp      = m_comp_reg;

  always_comb begin
    state_next  = state_reg;
    comp_next   = comp_reg;
    capture_in  = 1'b0;
    capture_out = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s_valid) begin
          capture_in = 1'b1;
          comp_next  = COMP_Y;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (p_ready) begin
          state_next = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (p_out_valid) begin
          capture_out = 1'b1;
          state_next  = EMIT;
        end else if (timeout_hit) begin
          comp_next  = COMP_Y;
          state_next = IDLE;
        end
      end
      EMIT: begin
        if (m_ready) begin
          if (comp_reg == COMP_CR) begin
            comp_next  = COMP_Y;
            state_next = IDLE;
          end else begin
            comp_next  = comp_reg + 2'd1;
            state_next = ISSUE;
          end
        end
      end
      default: begin
        comp_next  = COMP_Y;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      comp_reg  <= COMP_Y;
    end else begin
      state_reg <= state_next;
      comp_reg  <= comp_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_comp_reg <= COMP_Y;
    end else if (capture_out) begin
      m_comp_reg <= comp_reg;
    end
  end

  // Per-pixel storage: the RGB buffer is written only in IDLE, so the pipeline
  // sees stable planes for all three passes; it carries no reset.
  genvar gi;
  generate
    for (gi = 0; gi < PIXEL_COUNT; gi++) begin : g_pixel
      logic [INPUT_WIDTH-1:0] r_reg;
      logic [INPUT_WIDTH-1:0] g_reg;
      logic [INPUT_WIDTH-1:0] b_reg;
      logic [7:0]             coef_reg;

      always_ff @(posedge clk) begin
        if (capture_in) begin
          r_reg <= s_r[gi*INPUT_WIDTH +: INPUT_WIDTH];
          g_reg <= s_g[gi*INPUT_WIDTH +: INPUT_WIDTH];
          b_reg <= s_b[gi*INPUT_WIDTH +: INPUT_WIDTH];
        end
      end

      assign p_r[gi*INPUT_WIDTH +: INPUT_WIDTH] = r_reg;
      assign p_g[gi*INPUT_WIDTH +: INPUT_WIDTH] = g_reg;
      assign p_b[gi*INPUT_WIDTH +: INPUT_WIDTH] = b_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          coef_reg <= 8'd0;
        end else if (capture_out) begin
          coef_reg <= p_out_data[gi*8 +: 8];
        end
      end

      assign m_data[gi*8 +: 8] = coef_reg;
    end
  endgenerate

`ifdef SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt_reg;
  logic        err_reg;

  // Counter value k-1 during the k-th WAIT_RES cycle; the abort fires on the
  // TIMEOUT_CYCLES-th cycle unless a result arrives in that same cycle.
  assign timeout_hit = (state_reg == WAIT_RES) && !p_out_valid &&
                       (wd_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg <= 32'd0;
    end else if ((state_reg == ISSUE) && p_ready) begin
      wd_cnt_reg <= 32'd0;
    end else if (state_reg == WAIT_RES) begin
      wd_cnt_reg <= wd_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (timeout_hit) begin
      err_reg <= 1'b1;
    end
  end

  assign err_timeout = err_reg;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_ycbcr_component_scheduler.sv
// Randomized scoreboard bench for ycbcr_component_scheduler with a behavioural pipeline model.
// Build with SCHED_TIMEOUT_EN defined to exercise the watchdog path.
module tb_ycbcr_component_scheduler;
  localparam int IW = 8;
  localparam int PC = 64;
  localparam int PW = IW * PC;
  localparam int CW = 8 * PC;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready;
  logic [PW-1:0] s_r, s_g, s_b;
  logic          p_valid, p_ready;
  logic [PW-1:0] p_r, p_g, p_b;
  logic [1:0]    p_sel;
  logic          p_out_valid, p_out_ready;
  logic [CW-1:0] p_out_data;
  logic          m_valid, m_ready;
  logic [CW-1:0] m_data;
  logic [1:0]    m_comp;
  logic          m_last, busy, err_timeout;

  ycbcr_component_scheduler #(
    .INPUT_WIDTH(IW), .PIXEL_COUNT(PC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b),
    .p_valid(p_valid), .p_ready(p_ready), .p_r(p_r), .p_g(p_g), .p_b(p_b), .p_sel(p_sel),
    .p_out_valid(p_out_valid), .p_out_ready(p_out_ready), .p_out_data(p_out_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_comp(m_comp), .m_last(m_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [CW-1:0] data; logic [1:0] comp; logic last; } exp_t;
  typedef struct { logic [PW-1:0] r; logic [PW-1:0] g; logic [PW-1:0] b; } blk_t;
  exp_t exp_q[$];
  blk_t blk_q[$];
  int   issue_idx = 0;

  // Knobs shared by stimulus and the models
  int pipe_lat      = 5;
  bit pready_rand   = 0;
  int pready_hold   = -1;
  bit spurious      = 0;
  bit no_return     = 0;
  int mready_mode   = 0;
  int n_accepted    = 0;
  int n_beats       = 0;
  int last_acc_cyc  = 0;
  int last_cr_cyc   = -100;
  bit            job_valid = 0;
  logic [CW-1:0] job_data;
  int            job_due;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Reference "pipeline": integer colour transform per pixel, truncated to 8 bits
  function automatic logic [CW-1:0] ref_coefs(input logic [PW-1:0] r, input logic [PW-1:0] g,
                                              input logic [PW-1:0] b, input int comp);
    logic [CW-1:0] res;
    int rr, gg, bb, y, c;
    res = '0;
    for (int i = 0; i < PC; i++) begin
      rr = int'(r[i*IW +: IW]);
      gg = int'(g[i*IW +: IW]);
      bb = int'(b[i*IW +: IW]);
      y  = (77 * rr + 150 * gg + 29 * bb) / 256;
      case (comp)
        0:       c = y;
        1:       c = (bb - y) / 2 + 128;
        default: c = (rr - y) / 2 + 128;
      endcase
      res[i*8 +: 8] = c[7:0];
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] rand_plane();
    logic [PW-1:0] v;
    for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Behavioural pipeline: one job in flight, fixed latency, optional stalls
  initial begin
    p_ready = 1'b0; p_out_valid = 1'b0; p_out_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        job_valid = 0;
      end else begin
        if (p_out_valid && p_out_ready && job_valid) job_valid = 0;
        if (p_valid && p_ready) begin
          if (blk_q.size() == 0) begin
            fail_now("p_issue_without_block");
          end else begin
            check("p_sel_vs_comp", p_sel, issue_idx);
            check("p_r_buffer", p_r, blk_q[0].r);
            check("p_g_buffer", p_g, blk_q[0].g);
            check("p_b_buffer", p_b, blk_q[0].b);
            issue_idx++;
            if (issue_idx == 3) begin
              issue_idx = 0;
              void'(blk_q.pop_front());
            end
          end
          job_valid = 1;
          job_data  = ref_coefs(p_r, p_g, p_b, int'(p_sel));
          job_due   = cyc + pipe_lat;
        end
      end
      @(posedge clk); #1;
      if (pready_hold >= 0 && int'(p_sel) == pready_hold) p_ready = 1'b0;
      else p_ready = pready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (job_valid && !no_return && cyc >= job_due) begin
        p_out_valid = 1'b1; p_out_data = job_data;
      end else if (spurious && !job_valid) begin
        p_out_valid = 1'b1; p_out_data = rand_plane();
      end else begin
        p_out_valid = 1'b0; p_out_data = '0;
      end
    end
  end

  // Downstream ready driver: 0 = tied 1, 1 = random, 2 = held 0
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 1) == 1);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: records accepted blocks, pops/compares emitted beats, checks latencies
  initial begin
    bit   want_m, want_p;
    exp_t e;
    want_m = 0; want_p = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        want_m = 0; want_p = 0;
        continue;
      end
      if (want_m) check("lat_result_to_m_valid", m_valid, 1'b1);
      if (want_p) check("lat_to_p_valid", p_valid, 1'b1);
      want_m = p_out_valid && p_out_ready;
      want_p = 0;
      if (s_valid && s_ready) begin
        blk_t blk;
        blk.r = s_r; blk.g = s_g; blk.b = s_b;
        blk_q.push_back(blk);
        for (int c = 0; c < 3; c++) begin
          e.data = ref_coefs(s_r, s_g, s_b, c);
          e.comp = 2'(c);
          e.last = (c == 2);
          exp_q.push_back(e);
        end
        n_accepted++;
        last_acc_cyc = cyc;
        want_p = 1;
      end
      if (m_valid && m_ready) begin
        n_beats++;
        if (exp_q.size() == 0) begin
          fail_now("m_beat_unexpected");
        end else begin
          e = exp_q.pop_front();
          $display("beat cyc=%0d comp=%0d last=%0d", cyc, m_comp, m_last);
          check("m_data", m_data, e.data);
          check("m_comp", m_comp, e.comp);
          check("m_last", m_last, e.last);
        end
        if (m_comp == 2'd2) last_cr_cyc = cyc;
        else want_p = 1;
      end
    end
  end

  task automatic send_block(input logic [PW-1:0] r, input logic [PW-1:0] g,
                            input logic [PW-1:0] b, input bit keep_valid);
    int n0, t;
    n0 = n_accepted; t = 0;
    s_r = r; s_g = g; s_b = b; s_valid = 1'b1;
    while (n_accepted == n0 && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (n_accepted == n0) fail_now("s_accept_timeout");
    if (!keep_valid) s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 5000) fail_now("wait_idle_timeout");
  endtask

  task automatic wait_neg(input int sel, input int limit, output bit ok);
    int t;
    ok = 0; t = 0;
    while (!ok && t < limit) begin
      @(negedge clk); t++;
      case (sel)
        0: ok = m_valid;
        1: ok = p_valid && (p_sel == 2'd1);
        default: ok = p_out_ready;
      endcase
    end
  endtask

  task automatic flush_model();
    exp_q.delete(); blk_q.delete(); issue_idx = 0; job_valid = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 1'b1);
    check({tag, "_p_valid"}, p_valid, 1'b0);
    check({tag, "_p_out_ready"}, p_out_ready, 1'b0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_last"}, m_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err_timeout"}, err_timeout, 1'b0);
    check({tag, "_p_sel"}, p_sel, 2'd0);
    check({tag, "_m_comp"}, m_comp, 2'd0);
    check({tag, "_m_data"}, m_data, '0);
  endtask

  task automatic end_reset();
    @(posedge clk); @(posedge clk); #1;
    flush_model();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [PW-1:0] gray, pa, pb;
    logic [CW-1:0] snap_data;
    logic [1:0]    snap_comp;
    logic [PW-1:0] snap_r;
    int            beats0;
    bit            ok;

    rst = 1'b1; s_valid = 1'b0; s_r = '0; s_g = '0; s_b = '0;
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Gray block, 5-cycle pipeline, downstream always ready
    for (int i = 0; i < PC; i++) gray[i*IW +: IW] = 8'h80;
    mready_mode = 0; pipe_lat = 5; beats0 = n_beats;
    send_block(gray, gray, gray, 1'b0);
    wait_idle();
    check("gray_beat_count", n_beats - beats0, 3);

    // Downstream stall in EMIT
    mready_mode = 2;
    send_block(rand_plane(), rand_plane(), rand_plane(), 1'b0);
    wait_neg(0, 200, ok);
    if (!ok) fail_now("emit_wait");
    snap_data = m_data; snap_comp = m_comp;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_m_valid", m_valid, 1'b1);
      check("stall_m_data", m_data, snap_data);
      check("stall_m_comp", m_comp, snap_comp);
      check("stall_no_p_valid", p_valid, 1'b0);
      check("stall_s_ready", s_ready, 1'b0);
    end
    mready_mode = 0;
    @(posedge clk); #1;
    wait_idle();

    // Two blocks queued with s_valid held high, random stalls both sides
    pready_rand = 1; mready_mode = 1;
    pa = rand_plane(); pb = rand_plane();
    send_block(pa, pb, pa, 1'b1);
    send_block(pb, pa, pb, 1'b0);
    check("b2b_accept_cycle", last_acc_cyc, last_cr_cyc + 1);
    wait_idle();
    pready_rand = 0; mready_mode = 0;

    // Pipeline input stall on Cb plus a spurious result pulse
    pready_hold = 1;
    send_block(rand_plane(), rand_plane(), rand_plane(), 1'b0);
    wait_neg(1, 200, ok);
    if (!ok) fail_now("issue_cb_wait");
    snap_comp = p_sel; snap_r = p_r;
    for (int k = 0; k < 7; k++) begin
      spurious = (k >= 1 && k <= 3);
      @(negedge clk);
      check("issue_p_valid", p_valid, 1'b1);
      check("issue_p_sel", p_sel, snap_comp);
      check("issue_p_r", p_r, snap_r);
      check("issue_no_m_valid", m_valid, 1'b0);
    end
    spurious = 0; pready_hold = -1;
    @(posedge clk); #1;
    wait_idle();

    // Reset asserted mid-EMIT takes effect immediately
    mready_mode = 2;
    send_block(rand_plane(), rand_plane(), rand_plane(), 1'b0);
    wait_neg(0, 200, ok);
    if (!ok) fail_now("emit_wait_rst");
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    mready_mode = 0;
    end_reset();

    // Pipeline never returns a result
    no_return = 1;
    send_block(rand_plane(), rand_plane(), rand_plane(), 1'b0);
    wait_neg(2, 200, ok);
    if (!ok) fail_now("wait_res_entry");
`ifdef SCHED_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      if (k > 1) @(negedge clk);
      check("wd_err_before", err_timeout, 1'b0);
      check("wd_busy_before", busy, 1'b1);
    end
    @(negedge clk);
    check("wd_err_set", err_timeout, 1'b1);
    check("wd_back_idle", busy, 1'b0);
    check("wd_s_ready", s_ready, 1'b1);
    flush_model();
    repeat (5) @(negedge clk);
    check("wd_err_sticky", err_timeout, 1'b1);
    check("wd_no_m_valid", m_valid, 1'b0);
`else
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("nowd_err", err_timeout, 1'b0);
      check("nowd_busy", busy, 1'b1);
    end
`endif
    #2 rst = 1'b1;
    #1 check_reset_outputs("wd_rst");
    no_return = 0;
    end_reset();

    // Randomized traffic
    pready_rand = 1; mready_mode = 1; beats0 = n_beats;
    for (int n = 0; n < 20; n++) begin
      pipe_lat = $urandom_range(1, 8);
      send_block(rand_plane(), rand_plane(), rand_plane(), ($urandom_range(0, 1) == 1));
    end
    s_valid = 1'b0;
    wait_idle();
    check("rand_beat_count", n_beats - beats0, 60);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
